// File: rtl/mem_responder_pkg.sv
// Shared encodings for the memory responder: FSM states and latched request types.
package mem_responder_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACCESS,
    S_DONE
  } state_e;

  typedef enum logic [1:0] {
    OP_RD,
    OP_WR,
    OP_ERR
  } op_e;

  // Simultaneous read and write strobes form a conflicting request.
  function automatic op_e decode_op(input logic rd, input logic wr);
    if (rd && wr) begin
      return OP_ERR;
    end else if (wr) begin
      return OP_WR;
    end
    return OP_RD;
  endfunction

endpackage

// File: rtl/mem_responder_array.sv
// Synchronous single-port word RAM; read data is registered and has no reset.
module mem_responder_array #(
  parameter int AW = 10,
  parameter int DW = 16
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [DW-1:0] din_i,
  output logic [DW-1:0] dout_o
);

  logic [DW-1:0] mem_q [2**AW];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= din_i;
    end
    dout_o <= mem_q[addr_i];
  end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: accepts one word request, waits WAIT_STATES cycles,
// accesses the array and pulses mready_o for one cycle.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16,
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_STATES = 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              mread_i,
  input  logic              mwrite_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic              mready_o,
  output logic              mbusy_o,
  output logic              addr_err_o
);

  localparam logic [3:0] WAIT_LAST = 4'(WAIT_STATES - 1);

  state_e                  state_q, state_d;
  op_e                     op_q, op_d;
  logic [3:0]              cnt_q, cnt_d;
  logic                    oor_q, oor_d;
  logic [DEPTH_LOG2-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]       wdata_q, wdata_d;
  logic [DATA_W-1:0]       rdata_q, rdata_d;

  logic                    ram_we;
  logic [DEPTH_LOG2-1:0]   ram_addr;
  logic [DATA_W-1:0]       ram_dout;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      op_q    <= OP_RD;
      cnt_q   <= '0;
      oor_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      oor_q   <= oor_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    oor_d   = oor_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (mread_i || mwrite_i) begin
          op_d    = decode_op(mread_i, mwrite_i);
          oor_d   = |(addr_i >> DEPTH_LOG2);
          addr_d  = addr_i[DEPTH_LOG2-1:0];
          wdata_d = wdata_i;
          cnt_d   = '0;
          state_d = (WAIT_STATES == 0) ? S_ACCESS : S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q == WAIT_LAST) begin
          state_d = S_ACCESS;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_ACCESS: begin
        state_d = S_DONE;
        if (op_q == OP_RD) begin
          rdata_d = oor_q ? '0 : ram_dout;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // The RAM sees the live address while idle so its registered output is
  // already valid for the latched address by the time ACCESS is reached.
  assign ram_addr = (state_q == S_IDLE) ? addr_i[DEPTH_LOG2-1:0] : addr_q;
  assign ram_we   = (state_q == S_ACCESS) && (op_q == OP_WR) && !oor_q;

  mem_responder_array #(
    .AW (DEPTH_LOG2),
    .DW (DATA_W)
  ) u_array (
    .clk_i  (clk_i),
    .we_i   (ram_we),
    .addr_i (ram_addr),
    .din_i  (wdata_q),
    .dout_o (ram_dout)
  );

  assign rdata_o    = rdata_q;
  assign mready_o   = (state_q == S_DONE);
  assign mbusy_o    = (state_q != S_IDLE);
  assign addr_err_o = (state_q == S_DONE) && ((op_q == OP_ERR) || oor_q);

endmodule
